// File: rtl/arcade_input_ctrl_pkg.sv
// Shared constants for the arcade input controller: scan codes, pad/joystick bit
// positions and the coin/start sequencer state type.
package arcade_input_ctrl_pkg;

    localparam logic [7:0] ScanUp     = 8'h75;
    localparam logic [7:0] ScanDown   = 8'h72;
    localparam logic [7:0] ScanLeft   = 8'h6B;
    localparam logic [7:0] ScanRight  = 8'h74;
    localparam logic [7:0] ScanStart1 = 8'h05;
    localparam logic [7:0] ScanStart2 = 8'h06;
    localparam logic [7:0] ScanFire0  = 8'h14;
    localparam logic [7:0] ScanFire1  = 8'h11;
    localparam logic [7:0] ScanJump   = 8'h29;

    // Pad bit positions; the low six also match the joystick output layout.
    localparam int unsigned JoyRight  = 0;
    localparam int unsigned JoyLeft   = 1;
    localparam int unsigned JoyDown   = 2;
    localparam int unsigned JoyUp     = 3;
    localparam int unsigned JoyFire   = 4;
    localparam int unsigned JoyJump   = 5;
    localparam int unsigned JoyStart1 = 6;
    localparam int unsigned JoyStart2 = 7;

    localparam int unsigned OutStart = 6;
    localparam int unsigned OutCoin  = 7;

    typedef enum logic [1:0] {
        SeqIdle,
        SeqCoin,
        SeqGap,
        SeqStart
    } seq_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/arcade_coin_seq.sv
// Per-player coin/start sequencer: a start request produces a coin pulse, a gap,
// then a start pulse, each timed in cen ticks.
module arcade_coin_seq
    import arcade_input_ctrl_pkg::*;
#(
    parameter int unsigned COIN_TICKS  = 200000,
    parameter int unsigned GAP_TICKS   = 600000,
    parameter int unsigned START_TICKS = 700000
) (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic start_req,
    output logic in_coin,
    output logic in_start
);

    // A zero length would underflow the reload value; treat it as one tick.
    localparam int unsigned CoinT  = (COIN_TICKS  == 0) ? 1 : COIN_TICKS;
    localparam int unsigned GapT   = (GAP_TICKS   == 0) ? 1 : GAP_TICKS;
    localparam int unsigned StartT = (START_TICKS == 0) ? 1 : START_TICKS;
    localparam int unsigned MaxT   = max3(CoinT, GapT, StartT);
    localparam int unsigned CntW   = (MaxT > 1) ? $clog2(MaxT) : 1;

    localparam logic [CntW-1:0] CoinLoad  = CntW'(CoinT - 1);
    localparam logic [CntW-1:0] GapLoad   = CntW'(GapT - 1);
    localparam logic [CntW-1:0] StartLoad = CntW'(StartT - 1);

    seq_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start_req) begin
            // Retrigger from any state restarts the whole sequence.
            state_d = SeqCoin;
            cnt_d   = CoinLoad;
        end else if (state_q != SeqIdle && cen) begin
            if (cnt_q == '0) begin
                unique case (state_q)
                    SeqCoin: begin
                        state_d = SeqGap;
                        cnt_d   = GapLoad;
                    end
                    SeqGap: begin
                        state_d = SeqStart;
                        cnt_d   = StartLoad;
                    end
                    default: begin
                        state_d = SeqIdle;
                        cnt_d   = '0;
                    end
                endcase
            end else begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SeqIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_coin  = (state_q == SeqCoin);
    assign in_start = (state_q == SeqStart);

endmodule

// File: rtl/arcade_input_ctrl.sv
// Merges PS/2 keyboard and two pads into active-low arcade joystick words, and
// sequences coin/start pulses for each player's start request.
module arcade_input_ctrl
    import arcade_input_ctrl_pkg::*;
#(
    parameter int unsigned COIN_TICKS  = 200000,
    parameter int unsigned GAP_TICKS   = 600000,
    parameter int unsigned START_TICKS = 700000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [10:0] ps2_key,
    input  logic [8:0]  joy_0,
    input  logic [8:0]  joy_1,
    output logic [7:0]  joystick1,
    output logic [7:0]  joystick2
);

    logic       toggle_q;
    logic       key_event;
    logic [7:0] key_q, key_d;
    logic [7:0] joy_q;
    logic [7:0] active;
    logic       p1_coin, p1_start, p2_coin, p2_start;
    logic [7:0] joystick1_d, joystick2_d;
    logic       unused_bits;

    assign unused_bits = ^{ps2_key[8], joy_0[8], joy_1[8]};
    assign key_event   = (ps2_key[10] != toggle_q);

    // Key latches share the pad bit layout so they can be OR-ed directly.
    always_comb begin
        key_d = key_q;
        if (key_event) begin
            case (ps2_key[7:0])
                ScanUp:               key_d[JoyUp]     = ps2_key[9];
                ScanDown:             key_d[JoyDown]   = ps2_key[9];
                ScanLeft:             key_d[JoyLeft]   = ps2_key[9];
                ScanRight:            key_d[JoyRight]  = ps2_key[9];
                ScanStart1:           key_d[JoyStart1] = ps2_key[9];
                ScanStart2:           key_d[JoyStart2] = ps2_key[9];
                ScanFire0, ScanFire1: key_d[JoyFire]   = ps2_key[9];
                ScanJump:             key_d[JoyJump]   = ps2_key[9];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle_q <= 1'b0;
            key_q    <= '0;
            joy_q    <= '0;
        end else begin
            toggle_q <= ps2_key[10];
            key_q    <= key_d;
            joy_q    <= joy_0[7:0] | joy_1[7:0];
        end
    end

    assign active = key_q | joy_q;

    arcade_coin_seq #(
        .COIN_TICKS  (COIN_TICKS),
        .GAP_TICKS   (GAP_TICKS),
        .START_TICKS (START_TICKS)
    ) u_seq_p1 (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .start_req (active[JoyStart1]),
        .in_coin   (p1_coin),
        .in_start  (p1_start)
    );

    arcade_coin_seq #(
        .COIN_TICKS  (COIN_TICKS),
        .GAP_TICKS   (GAP_TICKS),
        .START_TICKS (START_TICKS)
    ) u_seq_p2 (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .start_req (active[JoyStart2]),
        .in_coin   (p2_coin),
        .in_start  (p2_start)
    );

    always_comb begin
        joystick1_d           = 8'hFF;
        joystick2_d           = 8'hFF;
        joystick1_d[5:0]      = ~active[5:0];
        joystick2_d[5:0]      = ~active[5:0];
        joystick1_d[OutStart] = ~p1_start;
        joystick2_d[OutStart] = ~p2_start;
        joystick1_d[OutCoin]  = ~(p1_coin | p2_coin);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            joystick1 <= 8'hFF;
            joystick2 <= 8'hFF;
        end else begin
            joystick1 <= joystick1_d;
            joystick2 <= joystick2_d;
        end
    end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Bench for arcade_input_ctrl: directed vector table, hand sequences for coin/start
// timing and reset, then random traffic against a behavioural model.
module tb_arcade_input_ctrl;

    localparam int unsigned CT = 4;
    localparam int unsigned GT = 3;
    localparam int unsigned ST = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        cen;
    logic [10:0] ps2_key;
    logic [8:0]  joy_0, joy_1;
    logic [7:0]  joystick1, joystick2;

    always #5 clk = ~clk;

    arcade_input_ctrl #(
        .COIN_TICKS  (CT),
        .GAP_TICKS   (GT),
        .START_TICKS (ST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .ps2_key   (ps2_key),
        .joy_0     (joy_0),
        .joy_1     (joy_1),
        .joystick1 (joystick1),
        .joystick2 (joystick2)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: pressed-key set, last pad sample, per-player phase with ticks left.
    bit         m_tog;
    bit [7:0]   m_key;
    bit [7:0]   m_joy;
    int         m_ph[2];   // 0 idle, 1 coin, 2 gap, 3 start
    int         m_left[2];
    logic [7:0] m_j1, m_j2;

    typedef struct {
        logic [10:0] ps2;
        logic [8:0]  j0;
        logic [8:0]  j1;
        logic [7:0]  e1;
        logic [7:0]  e2;
    } vec_t;

    vec_t vecs[26];

    function automatic int key_idx(input logic [7:0] c);
        case (c)
            8'h74: return 0;
            8'h6B: return 1;
            8'h72: return 2;
            8'h75: return 3;
            8'h14, 8'h11: return 4;
            8'h29: return 5;
            8'h05: return 6;
            8'h06: return 7;
            default: return -1;
        endcase
    endfunction

    function automatic void model_reset();
        m_tog = 0;
        m_key = '0;
        m_joy = '0;
        for (int p = 0; p < 2; p++) begin
            m_ph[p]   = 0;
            m_left[p] = 0;
        end
        m_j1 = 8'hFF;
        m_j2 = 8'hFF;
    endfunction

    // Advances the model across one rising edge using the inputs currently applied.
    function automatic void model_edge();
        bit [7:0] act;
        bit       coin;
        int       k;
        act  = m_key | m_joy;
        coin = (m_ph[0] == 1) || (m_ph[1] == 1);
        m_j1 = ~{coin, m_ph[0] == 3, act[5:0]};
        m_j2 = ~{1'b0, m_ph[1] == 3, act[5:0]};
        for (int p = 0; p < 2; p++) begin
            if (act[6+p]) begin
                m_ph[p]   = 1;
                m_left[p] = CT;
            end else if (m_ph[p] != 0 && cen) begin
                m_left[p]--;
                if (m_left[p] == 0) begin
                    if (m_ph[p] == 1) begin
                        m_ph[p]   = 2;
                        m_left[p] = GT;
                    end else if (m_ph[p] == 2) begin
                        m_ph[p]   = 3;
                        m_left[p] = ST;
                    end else begin
                        m_ph[p] = 0;
                    end
                end
            end
        end
        if (ps2_key[10] != m_tog) begin
            m_tog = ps2_key[10];
            k = key_idx(ps2_key[7:0]);
            if (k >= 0) m_key[k] = ps2_key[9];
        end
        m_joy = joy_0[7:0] | joy_1[7:0];
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic run_expect(input int n, input logic [7:0] e1, input logic [7:0] e2,
                              input string name);
        for (int i = 0; i < n; i++) begin
            step();
            chk({name, "_j1"}, joystick1, e1);
            chk({name, "_j2"}, joystick2, e2);
        end
    endtask

    function automatic logic [10:0] pk(input bit t, input bit pr, input bit ex,
                                       input logic [7:0] c);
        return {t, pr, ex, c};
    endfunction

    function automatic vec_t mk(input logic [10:0] p, input logic [8:0] a, input logic [8:0] b,
                                input logic [7:0] e1, input logic [7:0] e2);
        vec_t v;
        v.ps2 = p;
        v.j0  = a;
        v.j1  = b;
        v.e1  = e1;
        v.e2  = e2;
        return v;
    endfunction

    initial begin
        logic [7:0] codes[12];
        logic [8:0] r0, r1;

        vecs[0]  = mk(pk(0, 0, 0, 8'h00), 9'h000, 9'h000, 8'hFF, 8'hFF);
        vecs[1]  = mk(pk(1, 1, 0, 8'h75), 9'h000, 9'h000, 8'hFF, 8'hFF);
        vecs[2]  = mk(pk(1, 1, 0, 8'h75), 9'h000, 9'h000, 8'hF7, 8'hF7);
        vecs[3]  = mk(pk(1, 1, 0, 8'h75), 9'h000, 9'h000, 8'hF7, 8'hF7);
        vecs[4]  = mk(pk(0, 0, 0, 8'h75), 9'h000, 9'h000, 8'hF7, 8'hF7);
        vecs[5]  = mk(pk(0, 0, 0, 8'h75), 9'h000, 9'h000, 8'hFF, 8'hFF);
        vecs[6]  = mk(pk(1, 1, 0, 8'h1C), 9'h000, 9'h000, 8'hFF, 8'hFF);
        vecs[7]  = mk(pk(1, 1, 0, 8'h1C), 9'h000, 9'h000, 8'hFF, 8'hFF);
        vecs[8]  = mk(pk(1, 1, 0, 8'h29), 9'h000, 9'h000, 8'hFF, 8'hFF);
        vecs[9]  = mk(pk(1, 1, 0, 8'h29), 9'h000, 9'h000, 8'hFF, 8'hFF);
        vecs[10] = mk(pk(1, 1, 0, 8'h29), 9'h010, 9'h000, 8'hFF, 8'hFF);
        vecs[11] = mk(pk(1, 1, 0, 8'h29), 9'h010, 9'h000, 8'hEF, 8'hEF);
        vecs[12] = mk(pk(0, 1, 0, 8'h6B), 9'h000, 9'h001, 8'hEF, 8'hEF);
        vecs[13] = mk(pk(0, 1, 0, 8'h6B), 9'h000, 9'h001, 8'hFC, 8'hFC);
        vecs[14] = mk(pk(0, 1, 0, 8'h6B), 9'h000, 9'h000, 8'hFC, 8'hFC);
        vecs[15] = mk(pk(0, 1, 0, 8'h6B), 9'h000, 9'h000, 8'hFD, 8'hFD);
        vecs[16] = mk(pk(1, 0, 0, 8'h6B), 9'h000, 9'h000, 8'hFD, 8'hFD);
        vecs[17] = mk(pk(1, 0, 0, 8'h6B), 9'h000, 9'h000, 8'hFF, 8'hFF);
        vecs[18] = mk(pk(0, 1, 1, 8'h74), 9'h000, 9'h000, 8'hFF, 8'hFF);
        vecs[19] = mk(pk(0, 1, 1, 8'h74), 9'h000, 9'h000, 8'hFE, 8'hFE);
        vecs[20] = mk(pk(1, 0, 1, 8'h74), 9'h000, 9'h000, 8'hFE, 8'hFE);
        vecs[21] = mk(pk(1, 0, 1, 8'h74), 9'h000, 9'h000, 8'hFF, 8'hFF);
        vecs[22] = mk(pk(0, 1, 0, 8'h14), 9'h000, 9'h000, 8'hFF, 8'hFF);
        vecs[23] = mk(pk(0, 1, 0, 8'h14), 9'h000, 9'h000, 8'hEF, 8'hEF);
        vecs[24] = mk(pk(1, 0, 0, 8'h11), 9'h000, 9'h000, 8'hEF, 8'hEF);
        vecs[25] = mk(pk(1, 0, 0, 8'h11), 9'h000, 9'h000, 8'hFF, 8'hFF);

        codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h05, 8'h06, 8'h14, 8'h11, 8'h29, 8'h1C,
                  8'h00, 8'h5A};

        // Reset and idle
        rst     = 1'b1;
        cen     = 1'b1;
        ps2_key = '0;
        joy_0   = '0;
        joy_1   = '0;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_j1", joystick1, 8'hFF);
        chk("reset_j2", joystick2, 8'hFF);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_expect(20, 8'hFF, 8'hFF, "idle");

        // Vector table: key/pad mapping, latency, ignored events
        for (int i = 0; i < 26; i++) begin
            ps2_key = vecs[i].ps2;
            joy_0   = vecs[i].j0;
            joy_1   = vecs[i].j1;
            step();
            chk($sformatf("vec%0d_j1", i), joystick1, vecs[i].e1);
            chk($sformatf("vec%0d_j2", i), joystick2, vecs[i].e2);
        end
        joy_0 = '0;
        joy_1 = '0;
        run_expect(3, 8'hFF, 8'hFF, "settle");

        // Player 1 start pulse: coin, gap, start
        joy_0 = 9'h040;
        step();
        chk("p1pulse_j1", joystick1, 8'hFF);
        joy_0 = '0;
        run_expect(1, 8'hFF, 8'hFF, "p1_lat");
        run_expect(CT, 8'h7F, 8'hFF, "p1_coin");
        run_expect(GT, 8'hFF, 8'hFF, "p1_gap");
        run_expect(ST, 8'hBF, 8'hFF, "p1_start");
        run_expect(3, 8'hFF, 8'hFF, "p1_done");

        // Player 2 start pulse, retriggered during the gap
        joy_1 = 9'h080;
        step();
        chk("p2pulse_j1", joystick1, 8'hFF);
        joy_1 = '0;
        run_expect(1, 8'hFF, 8'hFF, "p2_lat");
        run_expect(CT, 8'h7F, 8'hFF, "p2_coin");
        joy_1 = 9'h080;
        step();
        chk("p2_retrig_j1", joystick1, 8'hFF);
        chk("p2_retrig_j2", joystick2, 8'hFF);
        joy_1 = '0;
        run_expect(1, 8'hFF, 8'hFF, "p2_gap1");
        run_expect(CT, 8'h7F, 8'hFF, "p2_coin2");
        run_expect(GT, 8'hFF, 8'hFF, "p2_gap2");
        run_expect(ST, 8'hFF, 8'hBF, "p2_start");
        run_expect(3, 8'hFF, 8'hFF, "p2_done");

        // Reset during player 1 start phase
        joy_0 = 9'h040;
        step();
        joy_0 = '0;
        run_expect(1, 8'hFF, 8'hFF, "r_lat");
        run_expect(CT, 8'h7F, 8'hFF, "r_coin");
        run_expect(GT, 8'hFF, 8'hFF, "r_gap");
        run_expect(2, 8'hBF, 8'hFF, "r_start");
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_j1", joystick1, 8'hFF);
        chk("async_rst_j2", joystick2, 8'hFF);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_expect(15, 8'hFF, 8'hFF, "post_rst");

        // Toggle high at reset release counts as one event
        rst     = 1'b1;
        ps2_key = pk(1, 1, 0, 8'h75);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_expect(1, 8'hFF, 8'hFF, "rel_evt0");
        run_expect(3, 8'hF7, 8'hF7, "rel_evt");

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cen = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           codes[$urandom_range(0, 11)]};
            end
            r0 = 9'($urandom & $urandom & $urandom);
            r1 = 9'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) != 0) r0[7:6] = 2'b00;
            if ($urandom_range(0, 15) != 0) r1[7:6] = 2'b00;
            joy_0 = r0;
            joy_1 = r1;
            step();
            chk("rand_j1", joystick1, m_j1);
            chk("rand_j2", joystick2, m_j2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arcade_input_ctrl.md
ARCADE_INPUT_CTRL -- requirements
Module: arcade_input_ctrl

Interface
REQ-001 SHALL have parameter COIN_TICKS, default 200000, number of cen ticks the coin bit is asserted per start request.
REQ-002 SHALL have parameter GAP_TICKS, default 600000, number of cen ticks between coin release and start assertion.
REQ-003 SHALL have parameter START_TICKS, default 700000, number of cen ticks the start bit is asserted.
REQ-004 clk  in  1  system clock; all logic on rising edge; single clock domain.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cen  in  1  tick enable for sequencer counters (1.5 MHz strobe, one clk wide).
REQ-007 ps2_key  in  11  [10] toggle-on-event, [9] pressed, [8] extended (ignored), [7:0] scan code.
REQ-008 joy_0, joy_1  in  9 each  active-high pad bits: [0]R [1]L [2]D [3]U [4]fire [5]jump [6]start1 [7]start2 [8]unused.
REQ-009 joystick1  out  8  active-low {coin,start,jump,fire,up,down,left,right} for player 1.
REQ-010 joystick2  out  8  active-low, same layout, bit 7 tied to 1 (coin only on joystick1).

Function
REQ-011 Key event SHALL be detected when ps2_key[10] differs from its registered copy; no event otherwise, regardless of other bits.
REQ-012 On event, latch for code SHALL load ps2_key[9]: 0x75 up, 0x72 down, 0x6B left, 0x74 right, 0x05 start1 (F1), 0x06 start2 (F2), 0x14 and 0x11 fire (shared latch), 0x29 jump; other codes ignored.
REQ-013 Directions/fire/jump SHALL be OR of key latch with (joy_0 | joy_1) bit; same values drive both players.
REQ-014 Raw start request n SHALL be key latch startn OR joy_0[5+n] OR joy_1[5+n].
REQ-015 Each player SHALL own a sequencer FSM: IDLE, COIN, GAP, START.
REQ-016 IDLE->COIN when raw start high (checked every clk); counter loaded with COIN_TICKS-1.
REQ-017 COIN->GAP, GAP->START, START->IDLE on a cen tick with counter==0, reloading GAP_TICKS-1 / START_TICKS-1; counter decrements only on cen.
REQ-018 Raw start high in COIN, GAP or START SHALL restart at COIN with full reload (retrigger); holding start keeps FSM in COIN.
REQ-019 Coin bit (active) = player1 FSM in COIN OR player2 FSM in COIN; start bit n active only in START.
REQ-020 All outputs SHALL be registered; ps2 event or joy change reaches joystickN exactly 2 clk edges later; FSM state change reaches output 1 edge later.
REQ-021 Simultaneous key event and joy change SHALL both take effect in the same cycle.
REQ-022 Counters SHALL be wide enough for the largest parameter; parameter value 0 treated as 1.

Reset
REQ-023 On rst: all key latches 0, ps2 toggle copy 0, both FSMs IDLE, counters 0, joystick1=joystick2=8'hFF.
REQ-024 rst asserted mid-sequence SHALL abort immediately; after release no coin/start pulse until a new request.
REQ-025 A ps2_key[10] value of 1 at rst release SHALL be seen as one event on the first clock.

Structure
REQ-026 Shared package SHALL hold scan-code constants, joystick bit-position constants and the sequencer state enum.
REQ-027 Sequencer SHALL be sub-module arcade_coin_seq, instantiated twice, parameters passed through.
REQ-028 Estimated 150-250 lines RTL total.

Verification (COIN_TICKS=4, GAP_TICKS=3, START_TICKS=5, cen every clk)
REQ-029 Reset then idle 20 clk -> joystick1=joystick2=8'hFF throughout.
REQ-030 ps2_key toggle with {pressed=1,code=0x75} -> joystick1[3]=0 and joystick2[3]=0 two edges later; release event (pressed=0) -> back to 1.
REQ-031 joy_0[6] one-clk pulse -> joystick1[7]=0 for 4 ticks, then 3 ticks all-high, then joystick1[6]=0 for 5 ticks, then 8'hFF; joystick2[6] never 0.
REQ-032 joy_1[7] pulse, repeated during GAP -> FSM restarts at COIN, joystick1[7]=0 4 more ticks, joystick2[6] asserted only after second GAP.
REQ-033 Unmapped code 0x1C and duplicate code without toggle change -> no output change.
REQ-034 rst pulse during START of player 1 -> joystick1=8'hFF asynchronously, stays high after release with no request.
